// File: rtl/rz_frame_scheduler.sv
// rz_frame_scheduler: reads the six ARINC429 receive RAMs round-robin into
// one ordered valid/ready word stream, one frame per start pulse.
// Ports: clock, reset (async, active-low), start, chan_en[5:0] (bit0 = line 1);
//   rd_arinc1..6 / arinc_1_outp..6 are RAM read address / read data;
//   out_data, out_chan, out_addr, out_valid, out_ready form the word stream;
//   busy and frame_done report frame status.
// Option: define RZ_SCHED_CHKSUM_EN to append a two's-complement checksum
//   word (out_chan=7, out_addr=0) after the last channel of each frame.
module rz_frame_scheduler #(
    parameter int WORDS   = 32,
    parameter int RAM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  chan_en,
    output logic [4:0]  rd_arinc1,
    output logic [4:0]  rd_arinc2,
    output logic [4:0]  rd_arinc3,
    output logic [4:0]  rd_arinc4,
    output logic [4:0]  rd_arinc5,
    output logic [4:0]  rd_arinc6,
    input  logic [15:0] arinc_1_outp,
    input  logic [15:0] arinc_2_outp,
    input  logic [15:0] arinc_3_outp,
    input  logic [15:0] arinc_4_outp,
    input  logic [15:0] arinc_5_outp,
    input  logic [15:0] arinc_6_outp,
    output logic [15:0] out_data,
    output logic [2:0]  out_chan,
    output logic [4:0]  out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE, SEL, ADDR, WAIT, PRESENT, CHK, DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(WORDS - 1);
    localparam logic [1:0] LAT  = 2'(RAM_LAT);

    state_t      state, state_n;
    logic [5:0]  mask, mask_n;
    logic [5:0]  served, served_n;
    logic [2:0]  sel, sel_n;
    logic [4:0]  cnt, cnt_n;
    logic [1:0]  wcnt, wcnt_n;
    logic [4:0]  rd_q [6];
    logic [4:0]  rd_n [6];
    logic [15:0] rdat [6];
    logic [15:0] data_n;
    logic [2:0]  chan_n;
    logic [4:0]  addr_n;
    logic        valid_n, busy_n, done_n;
    logic [5:0]  pend;
    logic [2:0]  pick;
`ifdef RZ_SCHED_CHKSUM_EN
    logic [15:0] sum, sum_n;
`endif

    assign rdat[0] = arinc_1_outp;
    assign rdat[1] = arinc_2_outp;
    assign rdat[2] = arinc_3_outp;
    assign rdat[3] = arinc_4_outp;
    assign rdat[4] = arinc_5_outp;
    assign rdat[5] = arinc_6_outp;

    assign rd_arinc1 = rd_q[0];
    assign rd_arinc2 = rd_q[1];
    assign rd_arinc3 = rd_q[2];
    assign rd_arinc4 = rd_q[3];
    assign rd_arinc5 = rd_q[4];
    assign rd_arinc6 = rd_q[5];

    // Scan high-to-low so the lowest pending channel is the one left in pick.
    always_comb begin
        pend = mask & ~served;
        pick = 3'd0;
        for (int i = 5; i >= 0; i--)
            if (pend[i]) pick = 3'(i);
    end

    always_comb begin
        state_n  = state;
        mask_n   = mask;
        served_n = served;
        sel_n    = sel;
        cnt_n    = cnt;
        wcnt_n   = wcnt;
        rd_n     = rd_q;
        data_n   = out_data;
        chan_n   = out_chan;
        addr_n   = out_addr;
        valid_n  = out_valid;
        busy_n   = busy;
        done_n   = 1'b0;
`ifdef RZ_SCHED_CHKSUM_EN
        sum_n    = sum;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    mask_n   = chan_en;
                    served_n = '0;
                    busy_n   = 1'b1;
`ifdef RZ_SCHED_CHKSUM_EN
                    sum_n    = '0;
`endif
                    state_n  = SEL;
                end
            end
            SEL: begin
                if (|pend) begin
                    sel_n   = pick;
                    cnt_n   = '0;
                    state_n = ADDR;
                end else begin
`ifdef RZ_SCHED_CHKSUM_EN
                    data_n  = ~sum + 16'd1;
                    chan_n  = 3'd7;
                    addr_n  = '0;
                    valid_n = 1'b1;
                    state_n = CHK;
`else
                    done_n  = 1'b1;
                    state_n = DONE;
`endif
                end
            end
            ADDR: begin
                for (int i = 0; i < 6; i++) rd_n[i] = '0;
                rd_n[sel] = cnt;
                wcnt_n    = LAT;
                state_n   = WAIT;
            end
            WAIT: begin
                // Address has been stable for RAM_LAT clocks on the last count.
                if (wcnt == 2'd1) begin
                    data_n  = rdat[sel];
                    chan_n  = sel + 3'd1;
                    addr_n  = cnt;
                    valid_n = 1'b1;
                    state_n = PRESENT;
                end else begin
                    wcnt_n = wcnt - 2'd1;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    valid_n = 1'b0;
`ifdef RZ_SCHED_CHKSUM_EN
                    sum_n   = sum + out_data;
`endif
                    if (cnt == LAST) begin
                        served_n[sel] = 1'b1;
                        state_n       = SEL;
                    end else begin
                        cnt_n   = cnt + 5'd1;
                        state_n = ADDR;
                    end
                end
            end
            CHK: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                busy_n = 1'b0;
                for (int i = 0; i < 6; i++) rd_n[i] = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mask       <= '0;
            served     <= '0;
            sel        <= '0;
            cnt        <= '0;
            wcnt       <= '0;
            rd_q       <= '{default: '0};
            out_data   <= '0;
            out_chan   <= '0;
            out_addr   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef RZ_SCHED_CHKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_n;
            mask       <= mask_n;
            served     <= served_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            wcnt       <= wcnt_n;
            rd_q       <= rd_n;
            out_data   <= data_n;
            out_chan   <= chan_n;
            out_addr   <= addr_n;
            out_valid  <= valid_n;
            busy       <= busy_n;
            frame_done <= done_n;
`ifdef RZ_SCHED_CHKSUM_EN
            sum        <= sum_n;
`endif
        end
    end

endmodule

// File: tb/tb_rz_frame_scheduler.sv
// tb_rz_frame_scheduler: directed bench for rz_frame_scheduler
// (WORDS=32, RAM_LAT=1) with a combinational RAM model per line.
module tb_rz_frame_scheduler;

`ifdef RZ_SCHED_CHKSUM_EN
    localparam int NCHK = 1;
`else
    localparam int NCHK = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic        out_valid, busy, frame_done;
    logic [5:0]  chan_en;
    logic [4:0]  rd1, rd2, rd3, rd4, rd5, rd6, out_addr;
    logic [15:0] d1, d2, d3, d4, d5, d6, out_data;
    logic [2:0]  out_chan;
    logic [15:0] mem [6][32];
    logic [15:0] esum;
    logic        act245 = 1'b0;
    int          passed = 0;
    int          total = 0;
    int          nacc = 0;
    int          ndone = 0;
    int          n, base, dbase;
    int          chs [3] = '{1, 3, 6};

    always #5 clk = ~clk;

    assign d1 = mem[0][rd1];
    assign d2 = mem[1][rd2];
    assign d3 = mem[2][rd3];
    assign d4 = mem[3][rd4];
    assign d5 = mem[4][rd5];
    assign d6 = mem[5][rd6];

    rz_frame_scheduler dut (
        .clock(clk), .reset(reset), .start(start), .chan_en(chan_en),
        .rd_arinc1(rd1), .rd_arinc2(rd2), .rd_arinc3(rd3),
        .rd_arinc4(rd4), .rd_arinc5(rd5), .rd_arinc6(rd6),
        .arinc_1_outp(d1), .arinc_2_outp(d2), .arinc_3_outp(d3),
        .arinc_4_outp(d4), .arinc_5_outp(d5), .arinc_6_outp(d6),
        .out_data(out_data), .out_chan(out_chan), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always @(posedge clk) begin
        if (out_valid && out_ready) nacc <= nacc + 1;
        if (frame_done) ndone <= ndone + 1;
        if (rd2 != 0 || rd4 != 0 || rd5 != 0) act245 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic get_word(input logic [2:0] c, input logic [4:0] a,
                            input logic [15:0] d, input int gap);
        int k;
        wait_valid(k);
        chk("gap", k, gap);
        chk("word", 32'({out_chan, out_addr, out_data}), 32'({c, a, d}));
        esum += d;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [5:0] en);
        chan_en = en;
        start   = 1'b1;
        esum    = '0;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic end_frame();
`ifdef RZ_SCHED_CHKSUM_EN
        get_word(3'd7, 5'd0, ~esum + 16'd1, 1);
        chk("done_pulse", 32'({frame_done, busy}), 32'b11);
`else
        chk("done_early", 32'({frame_done, busy}), 32'b01);
        @(negedge clk);
        chk("done_pulse", 32'({frame_done, busy}), 32'b11);
`endif
        @(negedge clk);
        chk("done_end", 32'({frame_done, busy}), 32'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; chan_en = '0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++)
            for (int a = 0; a < 32; a++)
                mem[c][a] = 16'((c + 1) * 256 + a);
        #1 reset = 1'b0;
        #1;
        chk("rst_word", 32'({out_chan, out_addr, out_data}), 0);
        chk("rst_ctl", 32'({out_valid, busy, frame_done}), 0);
        chk("rst_rd", 32'({rd1, rd2, rd3, rd4, rd5, rd6}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // channel 1 only, one word every 3 cycles
        pulse_start(6'b000001);
        for (int a = 0; a < 32; a++)
            get_word(3'd1, 5'(a), 16'h100 + 16'(a), a == 0 ? 3 : 2);
        end_frame();

        // channels 1,3,6; chan_en change mid-frame ignored
        pulse_start(6'b100101);
        chan_en = 6'h3f;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 32; a++)
                get_word(3'(chs[k]), 5'(a), 16'(chs[k] * 256 + a),
                         a == 0 ? 3 : 2);
        end_frame();
        chk("no_rd245", 32'(act245), 0);

        // backpressure on addr 7, start pulsed while busy
        pulse_start(6'b000001);
        base = nacc;
        for (int a = 0; a < 7; a++)
            get_word(3'd1, 5'(a), 16'h100 + 16'(a), a == 0 ? 3 : 2);
        out_ready = 1'b0;
        wait_valid(n);
        chk("bp_gap", n, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold",
                32'({out_valid, out_chan, out_addr, out_data}),
                32'({1'b1, 3'd1, 5'd7, 16'h107}));
            start = (i == 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_one", nacc - base, 8);
        esum += 16'h107;
        for (int a = 8; a < 32; a++)
            get_word(3'd1, 5'(a), 16'h100 + 16'(a), 2);
        end_frame();
        chk("bp_count", nacc - base, 32 + NCHK);
        repeat (6) @(negedge clk);
        chk("no_2nd_frame", 32'({busy, out_valid}), 0);
        chk("no_2nd_acc", nacc - base, 32 + NCHK);

        // all channels disabled
        base = nacc;
        pulse_start(6'b000000);
        end_frame();
        chk("zero_acc", nacc - base, NCHK);

        // reset at word 10 of channel 2, then restart from channel 1
        pulse_start(6'b000011);
        for (int a = 0; a < 32; a++)
            get_word(3'd1, 5'(a), 16'h100 + 16'(a), a == 0 ? 3 : 2);
        for (int a = 0; a < 10; a++)
            get_word(3'd2, 5'(a), 16'h200 + 16'(a), a == 0 ? 3 : 2);
        wait_valid(n);
        chk("r_w10", 32'({out_chan, out_addr, out_data}),
            32'({3'd2, 5'd10, 16'h20a}));
        dbase = ndone;
        #2 reset = 1'b0;
        #1;
        chk("abort_word", 32'({out_chan, out_addr, out_data}), 0);
        chk("abort_ctl", 32'({out_valid, busy, frame_done}), 0);
        chk("abort_rd", 32'({rd1, rd2, rd3, rd4, rd5, rd6}), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'({frame_done, busy, out_valid}), 0);
        chk("abort_nodone", ndone - dbase, 0);
        pulse_start(6'b000011);
        get_word(3'd1, 5'd0, 16'h100, 3);
        get_word(3'd1, 5'd1, 16'h101, 2);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef RZ_SCHED_CHKSUM_EN
        for (int a = 0; a < 32; a++) mem[0][a] = 16'd1;
        pulse_start(6'b000001);
        for (int a = 0; a < 32; a++)
            get_word(3'd1, 5'(a), 16'd1, a == 0 ? 3 : 2);
        get_word(3'd7, 5'd0, 16'hffe0, 1);
        chk("chk_done", 32'({frame_done, busy}), 32'b11);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
